inst_encoder: RTL
=================

// Module: inst_encoder
// PURPOSE
//  Command-issuing end of the 4-bit GPIO instruction link into the CNN accelerator's instruction decoder.
//  - Replaces the PS-side software sequencer for PL-only runs and board self-test.
//  - Sequence: on start, drives code 1 (start calculation, toggles net mode).
//  - Then walks codes 2..LAST_CODE, one batch read-out per code.
//  - Each code advance is paced by a downstream handshake, so the decoder always sees each code exactly once, in order.
// PARAMETERS
//  CODE_W      4      width of gpio_io_o command code
//  LAST_CODE   15     final code of a run; run = codes 1..LAST_CODE
//  HOLD_CYCLES 4      min cycles a code is driven before an ack may advance it (>=1)
//  TO_W        20     width of per-code timeout counter
//  TIMEOUT     20'hFFFFF   cycles in WAIT_ACK before timeout_err; 0 disables timeout
// PORTS
//  sys_clk      in   1       system clock, all logic rising-edge
//  rst          in   1       synchronous reset, active high
//  start        in   1       1-cycle pulse: begin a run (ignored unless IDLE or DONE/ERR)
//  abort        in   1       level/pulse: return to IDLE, drive code 0
//  batch_ack    in   1       1-cycle pulse: current code's work finished (cal done / batch consumed)
//  gpio_io_o    out  CODE_W  command code to decoder's gpio_io_i; 0 = idle
//  cur_code     out  CODE_W  code currently issued (same as gpio_io_o, 0 when idle)
//  mode_o       out  1       shadow of decoder mode: resets 1, toggles when code 1 is issued
//  busy         out  1       high in ISSUE/WAIT_ACK
//  done         out  1       1-cycle pulse after ack of LAST_CODE
//  timeout_err  out  1       sticky; set on timeout, cleared by start or rst
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; gpio_io_o=0, cur_code=0, mode_o=1, busy=0, done=0, timeout_err=0.
//    Counters and ack_pend are cleared.
//  States:
//    IDLE -start-> ISSUE with code<=1, mode_o<=~mode_o, timeout_err<=0.
//    ISSUE: gpio_io_o=code; hold_cnt counts 1..HOLD_CYCLES; at HOLD_CYCLES -> WAIT_ACK.
//    WAIT_ACK: gpio_io_o keeps code.
//      - On ack (batch_ack or ack_pend): if code==LAST_CODE -> DONE; else code<=code+1 -> ISSUE.
//      - to_cnt increments each cycle; reaching TIMEOUT (if nonzero) -> ERR.
//    DONE: done=1 for exactly this cycle; gpio_io_o<=0; next -> IDLE (start in DONE acts as in IDLE).
//    ERR: timeout_err=1, gpio_io_o=0, busy=0; stays until start (-> new run) or rst.
//  Latency:
//    - start to gpio_io_o=1: 1 cycle.
//    - Ack in WAIT_ACK to next code on gpio_io_o: 1 cycle.
//    - Min spacing between codes: HOLD_CYCLES+1.
//  Ack during ISSUE is latched in ack_pend (not lost); consumed on first WAIT_ACK cycle.
//    A second ack while pending is dropped.
//  Ack in IDLE/DONE/ERR: ignored, not latched.
//  start while busy: ignored (no restart, no mode toggle).
//  abort has priority over start/ack: -> IDLE, gpio_io_o=0, ack_pend cleared; mode_o unchanged.
//    The decoder is NOT rewound; a decoder reset is required before the next run.
//  Code only ever increments by 1, never wraps: LAST_CODE ends run, code 0 never issued mid-run.
//  hold_cnt/to_cnt reset to 0 on every state entry; to_cnt saturates.
//  rst mid-run: immediate return to reset values on that edge.
// TESTING
//  1) rst, start, ack each code 6 cycles after it appears -> gpio 1,2,..,15 in order, each held >=4 cycles.
//     done pulses once; gpio=0 after; mode_o 1->0.
//  2) Two back-to-back runs -> mode_o 1->0->1; second run again emits 1..15.
//  3) batch_ack asserted 1 cycle after code 3 appears (inside hold) -> code 4 appears exactly HOLD_CYCLES+1 cycles after code 3.
//     A double ack in hold advances only once.
//  4) start pulsed while busy at code 7 -> sequence continues 8..15, mode_o not toggled.
//  5) TIMEOUT=100, no ack on code 5 -> timeout_err=1 after 100 cycles, gpio=0.
//     Then start -> timeout_err=0, gpio=1.
//  6) abort at code 9 coincident with batch_ack -> next cycle gpio=0, busy=0, no code 10.
//     rst asserted mid-run -> all outputs at reset values.

Source files
------------

// File: rtl/inst_encoder_if.sv
// inst_encoder_if: command link between the instruction encoder and its controller / decoder side.
interface inst_encoder_if #(parameter int CODE_W = 4);
    logic              start;
    logic              abort;
    logic              batch_ack;
    logic [CODE_W-1:0] gpio_io_o;
    logic [CODE_W-1:0] cur_code;
    logic              mode_o;
    logic              busy;
    logic              done;
    logic              timeout_err;
    modport master (
        input  start, abort, batch_ack,
        output gpio_io_o, cur_code, mode_o, busy, done, timeout_err
    );
    modport slave (
        output start, abort, batch_ack,
        input  gpio_io_o, cur_code, mode_o, busy, done, timeout_err
    );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: issues command codes 1..LAST_CODE on the GPIO instruction link, one per downstream ack.
module inst_encoder #(
    parameter int          CODE_W      = 4,
    parameter int          LAST_CODE   = 15,
    parameter int          HOLD_CYCLES = 4,
    parameter int          TO_W        = 20,
    parameter int unsigned TIMEOUT     = 'hFFFFF
) (
    input logic             sys_clk,
    input logic             rst,
    inst_encoder_if.master  bus
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CODE_W-1:0] LAST      = CODE_W'(LAST_CODE);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, DONE, ERR} state_t;

    state_t            state, state_nx;
    logic [CODE_W-1:0] code, code_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              ack_pend;
    logic              mode;
    logic              err;
    logic              start_ok;
    logic              ack;
    logic              to_hit;

    assign start_ok = bus.start && !bus.abort && (state == IDLE || state == DONE || state == ERR);
    assign ack      = ack_pend || bus.batch_ack;
    assign to_hit   = TIMEOUT != 0 && to_cnt == TO_LAST;

    always_comb begin
        state_nx = state;
        code_nx  = code;
        case (state)
            IDLE, DONE, ERR: begin
                state_nx = start_ok ? ISSUE : (state == DONE ? IDLE : state);
                code_nx  = start_ok ? CODE_W'(1) : code;
            end
            ISSUE:
                state_nx = hold_cnt == HOLD_LAST ? WAIT_ACK : ISSUE;
            WAIT_ACK: begin
                state_nx = ack ? (code == LAST ? DONE : ISSUE) : (to_hit ? ERR : WAIT_ACK);
                code_nx  = ack && code != LAST ? code + 1'b1 : code;
            end
            default:
                state_nx = IDLE;
        endcase
        if (bus.abort)
            state_nx = IDLE;
    end

    // Counters restart on every state change; an ack seen while holding is kept for the first wait cycle.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= IDLE;
            code     <= '0;
            hold_cnt <= '0;
            to_cnt   <= '0;
            ack_pend <= 1'b0;
            mode     <= 1'b1;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            code     <= code_nx;
            hold_cnt <= (state_nx != state || state != ISSUE) ? '0 : hold_cnt + 1'b1;
            to_cnt   <= (state_nx != state || state != WAIT_ACK) ? '0 : (&to_cnt ? to_cnt : to_cnt + 1'b1);
            ack_pend <= state == ISSUE && !bus.abort && ack;
            mode     <= mode ^ start_ok;
            err      <= !start_ok && (err || state_nx == ERR);
        end
    end

    assign bus.busy        = state == ISSUE || state == WAIT_ACK;
    assign bus.gpio_io_o   = bus.busy ? code : '0;
    assign bus.cur_code    = bus.gpio_io_o;
    assign bus.mode_o      = mode;
    assign bus.done        = state == DONE;
    assign bus.timeout_err = err;
endmodule
